// File: rtl/mlp_pkg.sv
// Shared types, widths and the output activation function for the MLP layer engine.
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int ACT_W    = 8;   // activation / feature width
    localparam int PROD_W   = 17;  // {0,x} * w signed product width
    localparam int PIPE_LAT = 2;   // address-to-accumulate latency after the last issue
    localparam int SAT_IN_W = 64;  // width the accumulator is sign-extended to for sat_relu

    // ReLU, arithmetic shift right, then clamp into an unsigned 8-bit activation.
    function automatic logic [ACT_W-1:0] sat_relu(input logic signed [SAT_IN_W-1:0] a,
                                                  input int sh);
        logic signed [SAT_IN_W-1:0] s;
        if (a < 0) return '0;
        s = a >>> sh;
        if (s > 64'sd255) return 8'hFF;
        return s[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/mlp_layer_engine_if.sv
// Control, memory and result signals of the layer engine, bundled for the top-level port.
interface mlp_layer_engine_if #(
    parameter int LANES = 2,
    parameter int XAW   = 10,
    parameter int WAW   = 14,
    parameter int YAW   = 5,
    parameter int NW    = 10
);
    logic                   START_I;
    logic [NW-1:0]          N_IN_I;
    logic [NW-1:0]          N_OUT_I;
    logic                   MODE_I;
    logic                   BUSY_O;
    logic                   DONE_O;
    logic [LANES*XAW-1:0]   X_ADDR_O;
    logic [LANES*8-1:0]     X_READ_I;
    logic [LANES*WAW-1:0]   W_ADDR_O;
    logic [LANES*8-1:0]     W_READ_I;
    logic [YAW-1:0]         Y_ADDR_O;
    logic [7:0]             Y_DATA_O;
    logic                   Y_WE_O;
    logic [YAW-1:0]         CLASS_O;

    // Engine side
    modport slave (
        input  START_I, N_IN_I, N_OUT_I, MODE_I, X_READ_I, W_READ_I,
        output BUSY_O, DONE_O, X_ADDR_O, W_ADDR_O, Y_ADDR_O, Y_DATA_O, Y_WE_O, CLASS_O
    );

    // Controller / memory side
    modport master (
        output START_I, N_IN_I, N_OUT_I, MODE_I, X_READ_I, W_READ_I,
        input  BUSY_O, DONE_O, X_ADDR_O, W_ADDR_O, Y_ADDR_O, Y_DATA_O, Y_WE_O, CLASS_O
    );
endinterface

// File: rtl/mlp_mac_lane.sv
// One MAC lane: delays the issue mask to line up with returned data, then registers the product.
module mlp_mac_lane
    import mlp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACT_W-1:0]         x,
    input  logic signed [7:0]        w,
    output logic signed [PROD_W-1:0] prod
);
    logic                     mask_q;
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ws;

    assign xs = {{(PROD_W-ACT_W){1'b0}}, x};
    assign ws = {{(PROD_W-8){w[7]}}, w};

    // Mask follows the address by one cycle; a masked lane contributes zero whatever the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 1'b0;
            prod   <= '0;
        end else begin
            mask_q <= en;
            prod   <= mask_q ? xs * ws : '0;
        end
    end
endmodule

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: sequencing FSM, lane adder tree, accumulator and argmax tracker.
module mlp_layer_engine
    import mlp_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XAW   = 10,
    parameter int WAW   = 14,
    parameter int YAW   = 5,
    parameter int NW    = 10,
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic              CK,
    input  logic              RB,
    mlp_layer_engine_if.slave bus
);
    localparam int IW = NW + 1;

    state_t                   state;
    logic [NW-1:0]            n_in;
    logic [NW-1:0]            n_out;
    logic [NW-1:0]            o_idx;
    logic                     mode;
    logic [IW-1:0]            steps;
    logic [IW-1:0]            k_cnt;
    logic [IW-1:0]            i_base;
    logic [WAW-1:0]           w_base;
    logic [1:0]               drain_cnt;
    logic [LANES-1:0]         lane_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  best;
    logic signed [PROD_W-1:0] prod [LANES];

    logic [IW-1:0]            steps_c;
    logic [NW-1:0]            n_src;
    logic [IW-1:0]            nxt_ib;
    logic [WAW-1:0]           nxt_wb;
    logic [IW-1:0]            idx;
    logic [LANES*XAW-1:0]     nxt_x;
    logic [LANES*WAW-1:0]     nxt_w;
    logic [LANES-1:0]         nxt_en;
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  cmp;
    logic [ACT_W-1:0]         act;

    // Step count for the run being started: max(1, ceil(N_IN/LANES)).
    always_comb begin
        steps_c = (IW'(bus.N_IN_I) + IW'(LANES - 1)) / IW'(LANES);
        if (steps_c == '0) steps_c = IW'(1);
    end

    // Addresses and lane masks for the step about to be issued (first step of a neuron or the next one).
    always_comb begin
        n_src  = (state == ST_IDLE) ? bus.N_IN_I : n_in;
        nxt_ib = '0;
        nxt_wb = '0;
        if (state == ST_ISSUE) begin
            nxt_ib = i_base + IW'(LANES);
            nxt_wb = w_base;
        end else if (state == ST_WRITE) begin
            nxt_wb = w_base + WAW'(n_in);
        end
        idx    = '0;
        nxt_x  = '0;
        nxt_w  = '0;
        nxt_en = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = nxt_ib + IW'(l);
            if (idx < IW'(n_src)) begin
                nxt_en[l]              = 1'b1;
                nxt_x[l*XAW +: XAW]    = XAW'(idx);
                nxt_w[l*WAW +: WAW]    = nxt_wb + WAW'(idx);
            end
        end
    end

    // Adder tree, next accumulator value and the value argmax compares for this neuron.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
        acc_nxt = acc + lane_sum;
        act     = sat_relu({{(SAT_IN_W-ACC_W){acc_nxt[ACC_W-1]}}, acc_nxt}, SHIFT);
        cmp     = mode ? acc_nxt : {{(ACC_W-ACT_W){1'b0}}, act};
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mlp_mac_lane u_lane (
            .clk  (CK),
            .rst  (RB),
            .en   (lane_en[l]),
            .x    (bus.X_READ_I[l*8 +: 8]),
            .w    (bus.W_READ_I[l*8 +: 8]),
            .prod (prod[l])
        );
    end

    // Sequencer with registered outputs. The result is captured on the last DRAIN edge, where
    // acc_nxt already includes the final lane products, so WRITE can present it directly.
    always_ff @(posedge CK or posedge RB) begin
        if (RB) begin
            state        <= ST_IDLE;
            n_in         <= '0;
            n_out        <= '0;
            o_idx        <= '0;
            mode         <= 1'b0;
            steps        <= '0;
            k_cnt        <= '0;
            i_base       <= '0;
            w_base       <= '0;
            drain_cnt    <= '0;
            lane_en      <= '0;
            acc          <= '0;
            best         <= '0;
            bus.BUSY_O   <= 1'b0;
            bus.DONE_O   <= 1'b0;
            bus.X_ADDR_O <= '0;
            bus.W_ADDR_O <= '0;
            bus.Y_ADDR_O <= '0;
            bus.Y_DATA_O <= '0;
            bus.Y_WE_O   <= 1'b0;
            bus.CLASS_O  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START_I) begin
                        n_in        <= bus.N_IN_I;
                        n_out       <= bus.N_OUT_I;
                        mode        <= bus.MODE_I;
                        o_idx       <= '0;
                        best        <= '0;
                        bus.CLASS_O <= '0;
                        w_base      <= '0;
                        if (bus.N_OUT_I == '0) begin
                            state      <= ST_DONE;
                            bus.DONE_O <= 1'b1;
                        end else begin
                            state        <= ST_ISSUE;
                            bus.BUSY_O   <= 1'b1;
                            steps        <= steps_c;
                            k_cnt        <= '0;
                            i_base       <= '0;
                            acc          <= '0;
                            bus.X_ADDR_O <= nxt_x;
                            bus.W_ADDR_O <= nxt_w;
                            lane_en      <= nxt_en;
                        end
                    end
                end
                ST_ISSUE: begin
                    acc <= acc_nxt;
                    if (k_cnt == steps - IW'(1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                        lane_en   <= '0;
                    end else begin
                        k_cnt        <= k_cnt + IW'(1);
                        i_base       <= nxt_ib;
                        bus.X_ADDR_O <= nxt_x;
                        bus.W_ADDR_O <= nxt_w;
                        lane_en      <= nxt_en;
                    end
                end
                ST_DRAIN: begin
                    acc <= acc_nxt;
                    if (drain_cnt == 2'(PIPE_LAT - 1)) begin
                        state        <= ST_WRITE;
                        bus.Y_WE_O   <= ~mode;
                        bus.Y_ADDR_O <= YAW'(o_idx);
                        bus.Y_DATA_O <= act;
                        if (o_idx == '0 || cmp > best) begin
                            best        <= cmp;
                            bus.CLASS_O <= YAW'(o_idx);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_WRITE: begin
                    bus.Y_WE_O <= 1'b0;
                    o_idx      <= o_idx + NW'(1);
                    if (o_idx + NW'(1) == n_out) begin
                        state      <= ST_DONE;
                        bus.BUSY_O <= 1'b0;
                        bus.DONE_O <= 1'b1;
                    end else begin
                        state        <= ST_ISSUE;
                        k_cnt        <= '0;
                        i_base       <= '0;
                        w_base       <= nxt_wb;
                        acc          <= '0;
                        bus.X_ADDR_O <= nxt_x;
                        bus.W_ADDR_O <= nxt_w;
                        lane_en      <= nxt_en;
                    end
                end
                ST_DONE: begin
                    bus.DONE_O <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_layer_engine.sv
// Scoreboard bench: two engines (SHIFT=0 and SHIFT=2) share stimulus and memory contents;
// expected writes and classes come from a plain dot-product model of the layer.
module tb_mlp_layer_engine;
    localparam int LANES = 2;
    localparam int XAW   = 10;
    localparam int WAW   = 14;
    localparam int YAW   = 5;
    localparam int NW    = 10;
    localparam int ACC_W = 24;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic CK = 1'b0;
    logic RB = 1'b1;
    always #5 CK = ~CK;

    logic          start = 1'b0;
    logic [NW-1:0] n_in_v = '0;
    logic [NW-1:0] n_out_v = '0;
    logic          mode_v = 1'b0;

    logic [7:0] x_mem [0:(1<<XAW)-1];
    logic [7:0] w_mem [0:(1<<WAW)-1];

    mlp_layer_engine_if #(.LANES(LANES), .XAW(XAW), .WAW(WAW), .YAW(YAW), .NW(NW)) bus_a ();
    mlp_layer_engine_if #(.LANES(LANES), .XAW(XAW), .WAW(WAW), .YAW(YAW), .NW(NW)) bus_b ();

    mlp_layer_engine #(.LANES(LANES), .XAW(XAW), .WAW(WAW), .YAW(YAW), .NW(NW),
                       .ACC_W(ACC_W), .SHIFT(0)) dut_a (.CK(CK), .RB(RB), .bus(bus_a));
    mlp_layer_engine #(.LANES(LANES), .XAW(XAW), .WAW(WAW), .YAW(YAW), .NW(NW),
                       .ACC_W(ACC_W), .SHIFT(2)) dut_b (.CK(CK), .RB(RB), .bus(bus_b));

    assign bus_a.START_I = start;
    assign bus_a.N_IN_I  = n_in_v;
    assign bus_a.N_OUT_I = n_out_v;
    assign bus_a.MODE_I  = mode_v;
    assign bus_b.START_I = start;
    assign bus_b.N_IN_I  = n_in_v;
    assign bus_b.N_OUT_I = n_out_v;
    assign bus_b.MODE_I  = mode_v;

    // Synchronous multi-port memories, one cycle of read latency
    always @(posedge CK) begin
        for (int l = 0; l < LANES; l++) begin
            bus_a.X_READ_I[l*8 +: 8] <= x_mem[bus_a.X_ADDR_O[l*XAW +: XAW]];
            bus_a.W_READ_I[l*8 +: 8] <= w_mem[bus_a.W_ADDR_O[l*WAW +: WAW]];
            bus_b.X_READ_I[l*8 +: 8] <= x_mem[bus_b.X_ADDR_O[l*XAW +: XAW]];
            bus_b.W_READ_I[l*8 +: 8] <= w_mem[bus_b.W_ADDR_O[l*WAW +: WAW]];
        end
    end

    int  n_tests = 0;
    int  n_fail  = 0;
    int  jobs    = 0;
    int  done_a  = 0;
    int  done_b  = 0;
    wr_t exp_a [$];
    wr_t exp_b [$];
    int  cls_a [$];
    int  cls_b [$];

    function automatic void check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail_event(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endfunction

    // Reference model: neuron o is the dot product of x[0..nin-1] with w[o*nin ..]
    function automatic longint neuron_acc(int nin, int o);
        longint s = 0;
        for (int i = 0; i < nin; i++)
            s += longint'(x_mem[i]) * longint'($signed(w_mem[o*nin + i]));
        return s;
    endfunction

    function automatic longint act_fn(longint a, int sh);
        longint v;
        if (a < 0) return 0;
        v = a / (longint'(1) << sh);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor: pops expectations whenever a write or completion is presented
    always @(negedge CK) begin
        wr_t e;
        if (!RB) begin
            if (bus_a.Y_WE_O) begin
                if (exp_a.size() == 0) fail_event("unexpected_write_a");
                else begin
                    e = exp_a.pop_front();
                    check("y_addr_a", bus_a.Y_ADDR_O, e.addr);
                    check("y_data_a", bus_a.Y_DATA_O, e.data);
                end
            end
            if (bus_b.Y_WE_O) begin
                if (exp_b.size() == 0) fail_event("unexpected_write_b");
                else begin
                    e = exp_b.pop_front();
                    check("y_addr_b", bus_b.Y_ADDR_O, e.addr);
                    check("y_data_b", bus_b.Y_DATA_O, e.data);
                end
            end
            if (bus_a.DONE_O) begin
                done_a++;
                if (cls_a.size() == 0) fail_event("unexpected_done_a");
                else check("class_a", bus_a.CLASS_O, cls_a.pop_front());
            end
            if (bus_b.DONE_O) begin
                done_b++;
                if (cls_b.size() == 0) fail_event("unexpected_done_b");
                else check("class_b", bus_b.CLASS_O, cls_b.pop_front());
            end
        end
    end

    task automatic run_job(input int nin, input int nout, input int md, input bit hold_start);
        int     s, done_exp, c, o, k, i;
        bit     got;
        longint a, va, vb, ca, cb, best_a, best_b;
        int     ba, bb;
        s        = (nin == 0) ? 1 : (nin + LANES - 1) / LANES;
        done_exp = 1 + nout * (s + 3);
        best_a = 0; best_b = 0; ba = 0; bb = 0;
        for (int n = 0; n < nout; n++) begin
            a  = neuron_acc(nin, n);
            va = act_fn(a, 0);
            vb = act_fn(a, 2);
            if (md == 0) begin
                exp_a.push_back('{addr: n, data: int'(va)});
                exp_b.push_back('{addr: n, data: int'(vb)});
            end
            ca = (md != 0) ? a : va;
            cb = (md != 0) ? a : vb;
            if (n == 0 || ca > best_a) begin best_a = ca; ba = n; end
            if (n == 0 || cb > best_b) begin best_b = cb; bb = n; end
        end
        cls_a.push_back(ba);
        cls_b.push_back(bb);
        jobs++;

        @(negedge CK);
        start   = 1'b1;
        n_in_v  = NW'(nin);
        n_out_v = NW'(nout);
        mode_v  = md[0];
        @(posedge CK);
        c   = 0;
        got = 1'b0;
        while (!got && c < done_exp + 20) begin
            @(negedge CK);
            c++;
            if (!hold_start) start = 1'b0;
            if (nout > 0) begin
                o = (c - 1) / (s + 3);
                k = (c - 1) % (s + 3);
                if (o < nout && k < s) begin
                    for (int l = 0; l < LANES; l++) begin
                        i = k * LANES + l;
                        check("x_addr", bus_a.X_ADDR_O[l*XAW +: XAW], (i < nin) ? i : 0);
                        check("w_addr", bus_a.W_ADDR_O[l*WAW +: WAW], (i < nin) ? o*nin + i : 0);
                    end
                end
            end
            check("busy", bus_a.BUSY_O, (c < done_exp) ? 1 : 0);
            if (bus_a.DONE_O) begin
                got = 1'b1;
                check("done_cycle", c, done_exp);
                start = 1'b0;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no DONE_O within %0d cycles, expected at %0d", c, done_exp);
            start = 1'b0;
        end
        repeat (3) @(negedge CK);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  bus_a.BUSY_O, 0);
        check({tag, "_done"},  bus_a.DONE_O, 0);
        check({tag, "_we"},    bus_a.Y_WE_O, 0);
        check({tag, "_yaddr"}, bus_a.Y_ADDR_O, 0);
        check({tag, "_ydata"}, bus_a.Y_DATA_O, 0);
        check({tag, "_xaddr"}, bus_a.X_ADDR_O, 0);
        check({tag, "_waddr"}, bus_a.W_ADDR_O, 0);
        check({tag, "_class"}, bus_a.CLASS_O, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nin, nout;
        for (int i = 0; i < (1<<XAW); i++) x_mem[i] = 8'($urandom);
        for (int i = 0; i < (1<<WAW); i++) w_mem[i] = 8'($urandom);
        repeat (3) @(negedge CK);
        check_idle_outputs("reset");
        RB = 1'b0;
        repeat (2) @(negedge CK);

        // Nominal: Y = {10, 7}, class 0, DONE at cycle 11
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3; x_mem[3] = 8'd4;
        for (int i = 0; i < 4; i++) w_mem[i] = 8'd1;
        w_mem[4] = 8'hFF; w_mem[5] = 8'd2; w_mem[6] = 8'd0; w_mem[7] = 8'd1;
        run_job(4, 2, 0, 1'b0);

        // Lane masking: odd N_IN, junk beyond the valid range
        x_mem[3] = 8'hFF;
        w_mem[0] = 8'd2; w_mem[1] = 8'd2; w_mem[2] = 8'd2; w_mem[3] = 8'hFF;
        run_job(3, 1, 0, 1'b0);

        // Activation: negative clamps to 0; 300 saturates (SHIFT=0) or becomes 75 (SHIFT=2)
        x_mem[0] = 8'd50; w_mem[0] = 8'hFF;
        run_job(1, 1, 0, 1'b0);
        x_mem[0] = 8'd100; x_mem[1] = 8'd100; x_mem[2] = 8'd100;
        w_mem[0] = 8'd1; w_mem[1] = 8'd1; w_mem[2] = 8'd1;
        run_job(3, 1, 0, 1'b0);

        // Argmax-only: accs [-5,-3,-3] -> class 1, no writes
        x_mem[0] = 8'd1;
        w_mem[0] = 8'hFB; w_mem[1] = 8'hFD; w_mem[2] = 8'hFD;
        run_job(1, 3, 1, 1'b0);

        // START held high through the run: exactly one completion
        run_job(4, 2, 0, 1'b1);

        // N_OUT = 0 and N_IN = 0 corner cases
        run_job(4, 0, 0, 1'b0);
        run_job(0, 2, 0, 1'b0);

        // Reset in the middle of ISSUE: everything zero, no later write or completion
        @(negedge CK);
        start = 1'b1; n_in_v = NW'(8); n_out_v = NW'(3); mode_v = 1'b0;
        @(posedge CK);
        @(negedge CK); start = 1'b0;
        @(negedge CK);
        RB = 1'b1;
        @(posedge CK); #1;
        check_idle_outputs("midrun_reset");
        @(negedge CK); RB = 1'b0;
        repeat (40) @(negedge CK);

        // Randomised jobs
        for (int j = 0; j < 10; j++) begin
            nin  = $urandom_range(0, 12);
            nout = $urandom_range(1, 6);
            for (int i = 0; i < 16; i++) x_mem[i] = 8'($urandom);
            for (int i = 0; i < 80; i++) w_mem[i] = 8'($urandom);
            run_job(nin, nout, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CK);
        check("pending_writes_a", exp_a.size(), 0);
        check("pending_writes_b", exp_b.size(), 0);
        check("done_count_a", done_a, jobs);
        check("done_count_b", done_b, jobs);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
